// File: rtl/led_strip_driver_if.sv
// -----------------------------------------------------------------------------
// led_strip_driver_if
//
// Connection between the game engine and the LED strip driver.
//
// Signals:
//   frame  ROWS*COLS  pixel matrix; bit r*COLS+c is row r, column c; 1 = on
//   start  1          request to send frame (engine -> driver)
//   busy   1          driver is sending a frame or holding the latch gap
//   done   1          one-cycle pulse when a frame's latch gap completes
//   dout   1          LED data line
//
// Modports:
//   master  engine / top-level side (drives frame and start)
//   slave   driver side (drives busy, done, dout)
// -----------------------------------------------------------------------------
interface led_strip_driver_if #(
    parameter int ROWS = 16,
    parameter int COLS = 12
);
    logic [ROWS*COLS-1:0] frame;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 dout;

    modport master (
        output frame,
        output start,
        input  busy,
        input  done,
        input  dout
    );

    modport slave (
        input  frame,
        input  start,
        output busy,
        output done,
        output dout
    );
endinterface

// File: rtl/led_strip_driver.sv
// -----------------------------------------------------------------------------
// led_strip_driver
//
// Serializes a ROWS x COLS on/off pixel matrix onto a WS2812-style data line.
// On start (while idle) the frame is copied into a shadow register, then every
// LED is sent as a 24-bit GRB word, MSB first: ON_COLOR for a lit pixel, zero
// for an unlit one. Each bit is a high pulse of T0H or T1H cycles followed by
// low time up to TBIT cycles. After the last bit the line is held low for
// TRESET cycles so the strip latches; done pulses when that gap ends.
// After reset the same gap is run once (without a done pulse) so a frame cut
// short by reset still ends in a clean latch.
//
// Ports:
//   CLOCK_50  in   system clock, the only clock
//   reset     in   synchronous, active-high reset
//   bus       slave modport of led_strip_driver_if
//             (frame, start in; busy, done, dout out)
// -----------------------------------------------------------------------------
module led_strip_driver #(
    parameter int          ROWS       = 16,
    parameter int          COLS       = 12,
    parameter logic [23:0] ON_COLOR   = 24'h100000,
    parameter bit          SERPENTINE = 1'b1,
    parameter int          TBIT       = 63,
    parameter int          T0H        = 20,
    parameter int          T1H        = 40,
    parameter int          TRESET     = 3000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    led_strip_driver_if.slave  bus
);
    localparam int NUM_LEDS   = ROWS * COLS;
    localparam int TOTAL_BITS = 24 * NUM_LEDS;
    localparam int CNT_MAX    = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PIX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [1:0] S_GAP  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    generate
        if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TRESET > 0)) begin : g_bad_timing
            $error("led_strip_driver: timing parameters must satisfy 0 < T0H < T1H < TBIT and TRESET > 0");
        end
    endgenerate

    // Bit of the GRB word at position pos (0 = MSB) for a pixel that is lit or not.
    function automatic logic color_bit(input logic lit, input logic [4:0] pos);
        return lit & ON_COLOR[5'd23 - pos];
    endfunction

    logic [1:0]          state;
    logic [CNT_W-1:0]    cyc_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [4:0]          word_bit;
    logic [ROW_W-1:0]    row_idx;
    logic [COL_W-1:0]    pos_idx;
    logic [NUM_LEDS-1:0] shadow;
    logic                report_done;
    logic                done_q;

    logic [COL_W-1:0]    col_sel;
    logic [PIX_W-1:0]    pix_addr;
    logic                pixel_on;
    logic                cur_bit;
    logic [CNT_W-1:0]    high_last;
    logic                accept;

    assign accept = (state == S_IDLE) && bus.start;

    // Map the strip position (row, position along the row) to a matrix column.
    // Odd rows run right-to-left when the strip is wired serpentine.
    always_comb begin
        col_sel = pos_idx;
        if (SERPENTINE && row_idx[0]) begin
            col_sel = COL_W'(COLS - 1) - pos_idx;
        end
        pix_addr  = PIX_W'(row_idx) * PIX_W'(COLS) + PIX_W'(col_sel);
        pixel_on  = shadow[pix_addr];
        cur_bit   = color_bit(pixel_on, word_bit);
        high_last = cur_bit ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
    end

    // The shadow copy is pure data: it only needs to be valid once a frame
    // has been accepted, so it carries no reset.
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            shadow <= bus.frame;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= S_GAP;
            cyc_cnt     <= '0;
            bit_idx     <= '0;
            word_bit    <= '0;
            row_idx     <= '0;
            pos_idx     <= '0;
            report_done <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_GAP: begin
                    if (cyc_cnt == CNT_W'(TRESET - 1)) begin
                        state       <= S_IDLE;
                        cyc_cnt     <= '0;
                        // Only a gap that closes a transmitted frame reports done.
                        done_q      <= report_done;
                        report_done <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                S_IDLE: begin
                    if (bus.start) begin
                        state       <= S_HIGH;
                        cyc_cnt     <= '0;
                        bit_idx     <= '0;
                        word_bit    <= '0;
                        row_idx     <= '0;
                        pos_idx     <= '0;
                        report_done <= 1'b1;
                    end
                end

                // The cycle counter keeps running from HIGH into LOW so the two
                // phases together always span exactly TBIT cycles.
                S_HIGH: begin
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
                    if (cyc_cnt == high_last) begin
                        state <= S_LOW;
                    end
                end

                S_LOW: begin
                    if (cyc_cnt == CNT_W'(TBIT - 1)) begin
                        cyc_cnt <= '0;
                        if (bit_idx == BIT_W'(TOTAL_BITS - 1)) begin
                            state <= S_GAP;
                        end else begin
                            state   <= S_HIGH;
                            bit_idx <= bit_idx + BIT_W'(1);
                            if (word_bit == 5'd23) begin
                                word_bit <= '0;
                                if (pos_idx == COL_W'(COLS - 1)) begin
                                    pos_idx <= '0;
                                    row_idx <= row_idx + ROW_W'(1);
                                end else begin
                                    pos_idx <= pos_idx + COL_W'(1);
                                end
                            end else begin
                                word_bit <= word_bit + 5'd1;
                            end
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= S_GAP;
                    cyc_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.dout = (state == S_HIGH);
    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;

endmodule

// File: tb/tb_led_strip_driver.sv
// -----------------------------------------------------------------------------
// tb_led_strip_driver
//
// Directed sequence with randomized frames for led_strip_driver, using a small
// matrix and short timing so whole frames fit in a short run. Expected line
// behaviour is computed from the strip-order and colour rules.
// -----------------------------------------------------------------------------
module tb_led_strip_driver;
    localparam int          ROWS       = 4;
    localparam int          COLS       = 3;
    localparam logic [23:0] ON_COLOR   = 24'h100081;
    localparam bit          SERPENTINE = 1'b1;
    localparam int          TBIT       = 10;
    localparam int          T0H        = 3;
    localparam int          T1H        = 6;
    localparam int          TRESET     = 40;
    localparam int          NPIX       = ROWS * COLS;
    localparam int          NBITS      = 24 * NPIX;

    logic clk = 1'b0;
    logic reset = 1'b1;

    led_strip_driver_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_strip_driver #(
        .ROWS(ROWS), .COLS(COLS), .ON_COLOR(ON_COLOR), .SERPENTINE(SERPENTINE),
        .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value of global bit idx on the strip for a given frame.
    function automatic logic exp_bit(input logic [NPIX-1:0] f, input int idx);
        int k, b, r, j, c;
        k = idx / 24;
        b = 23 - (idx % 24);
        r = k / COLS;
        j = k % COLS;
        c = (SERPENTINE && (r % 2 == 1)) ? (COLS - 1 - j) : j;
        return f[r * COLS + c] ? ON_COLOR[b] : 1'b0;
    endfunction

    // Sends frame f starting now (caller guarantees busy=0) and checks every
    // bit, the latch gap and the done pulse. Ends in the done cycle.
    // At bit mid_bit the input frame is flipped to all-ones and start pulsed.
    task automatic run_frame(input logic [NPIX-1:0] f, input int mid_bit, input string tag);
        int hi;
        bit shape_ok, flags_ok, gap_ok;
        bus.frame = f;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, " busy after start"}, 32'(bus.busy), 32'd1);
        for (int i = 0; i < NBITS; i++) begin
            int th;
            th = exp_bit(f, i) ? T1H : T0H;
            hi = 0;
            shape_ok = 1'b1;
            flags_ok = 1'b1;
            for (int t = 0; t < TBIT; t++) begin
                if (bus.dout !== ((t < th) ? 1'b1 : 1'b0)) shape_ok = 1'b0;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) flags_ok = 1'b0;
                if (bus.dout === 1'b1) hi++;
                if (i == mid_bit && t == 0) begin
                    bus.frame = '1;
                    bus.start = 1'b1;
                end
                if (i == mid_bit && t == 1) bus.start = 1'b0;
                tick();
            end
            check($sformatf("%s bit%0d high cycles", tag, i), 32'(hi), 32'(th));
            check($sformatf("%s bit%0d shape/flags", tag, i), {30'd0, shape_ok, flags_ok}, 32'd3);
        end
        gap_ok = 1'b1;
        for (int t = 0; t < TRESET; t++) begin
            if (bus.dout !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) gap_ok = 1'b0;
            tick();
        end
        check({tag, " latch gap"}, 32'(gap_ok), 32'd1);
        check({tag, " done/busy/dout at gap end"}, {29'd0, bus.done, bus.busy, bus.dout}, 32'b100);
    endtask

    initial begin
        logic [NPIX-1:0] f;
        bit ok;
        bus.frame = '0;
        bus.start = 1'b0;

        // Reset recovery: 5 cycles of reset, then a full gap without done.
        reset = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.dout !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
        end
        check("reset outputs", 32'(ok), 32'd1);
        reset = 1'b0;
        ok = 1'b1;
        for (int t = 0; t < TRESET; t++) begin
            if (bus.dout !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
            tick();
        end
        check("post-reset gap", 32'(ok), 32'd1);
        check("post-reset idle busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        tick();
        check("idle stays idle", {30'd0, bus.busy, bus.done}, 32'd0);

        // All-off frame.
        run_frame('0, -1, "all-off");
        tick();
        check("done single pulse", {30'd0, bus.done, bus.busy}, 32'd0);

        // Single lit pixel at row 0, col 0.
        f = '0;
        f[0] = 1'b1;
        run_frame(f, -1, "pix r0c0");

        // Serpentine: row 1, col 0 (back-to-back start in the done cycle).
        f = '0;
        f[1 * COLS + 0] = 1'b1;
        run_frame(f, -1, "pix r1c0");

        // Randomized frames, back to back.
        for (int n = 0; n < 3; n++) begin
            f = NPIX'($urandom);
            run_frame(f, -1, $sformatf("rand%0d", n));
        end

        // Latching and ignored start mid-frame.
        tick();
        f = NPIX'($urandom);
        run_frame(f, 50, "latch");
        bus.frame = '0;
        ok = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout !== 1'b0) ok = 1'b0;
        end
        check("ignored start not queued", 32'(ok), 32'd1);

        // Reset mid-frame, during bit 100.
        f = NPIX'($urandom);
        bus.frame = f;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int t = 0; t < 100 * TBIT + 1; t++) tick();
        check("mid-frame dout before reset", 32'(bus.dout), 32'd1);
        reset = 1'b1;
        tick();
        check("mid-frame reset outputs", {29'd0, bus.dout, bus.busy, bus.done}, 32'b010);
        tick();
        reset = 1'b0;
        ok = 1'b1;
        for (int t = 0; t < TRESET; t++) begin
            if (bus.dout !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
            tick();
        end
        check("mid-frame reset gap", 32'(ok), 32'd1);
        check("mid-frame reset no done", {30'd0, bus.busy, bus.done}, 32'd0);

        // A complete frame from bit 0 after the interrupted one.
        f = NPIX'($urandom);
        run_frame(f, -1, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
